thread_dispatcher: RTL and testbench

- Kernel-launch sequencer that sits directly upstream of the single-thread GPU core.
- Accepts a launch request (block count, threads per block) and runs every (block, thread) pair on the core, one at a time.
- For each pair it resets the core, drives the block_idx/block_dim/thread_idx values the core's register file consumes, waits for the core to finish, then advances.
- Reports launch completion, thread count and watchdog timeout.

---
 rtl/thread_dispatcher.sv | 149 ++++++++++++++
 tb/tb_thread_dispatcher.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/thread_dispatcher.sv
// Kernel-launch sequencer: runs every (block, thread) pair of a launch on a single-thread core.
// First RUN cycle comes 1+RST_CYCLES cycles after an accepted start; start is ignored while a launch is active.
module thread_dispatcher #(
  parameter int WIDTH      = 16,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] num_blocks,
  input  logic [WIDTH-1:0] block_dim_in,
  input  logic             core_done,
  output logic             core_reset,
  output logic [WIDTH-1:0] core_block_idx,
  output logic [WIDTH-1:0] core_thread_idx,
  output logic [WIDTH-1:0] core_block_dim,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] threads_done
);

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CORE_RST,
    S_RUN,
    S_ADVANCE,
    S_FINISH
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_num_blocks;
  logic [WIDTH-1:0] r_block_dim;
  logic [WIDTH-1:0] r_block_idx;
  logic [WIDTH-1:0] r_thread_idx;
  logic [WIDTH-1:0] r_threads_done;
  logic             r_error;
  logic [RCW-1:0]   r_rst_cnt;
  logic [WCW-1:0]   r_wdog;

  logic w_last_thread;
  logic w_last_block;
  logic w_rst_end;
  logic w_timeout;

  assign w_last_thread = (r_thread_idx == r_block_dim - WIDTH'(1));
  assign w_last_block  = (r_block_idx == r_num_blocks - WIDTH'(1));
  assign w_rst_end     = (r_rst_cnt == RCW'(RST_CYCLES - 1));
  assign w_timeout     = (r_wdog == WCW'(TIMEOUT - 1));

  always_comb begin
    w_next     = r_state;
    core_reset = 1'b1;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          // Empty grids skip straight to the completion pulse.
          if (num_blocks == '0 || block_dim_in == '0) w_next = S_FINISH;
          else                                         w_next = S_CORE_RST;
        end
      end
      S_CORE_RST: begin
        busy = 1'b1;
        if (w_rst_end) w_next = S_RUN;
      end
      S_RUN: begin
        busy       = 1'b1;
        core_reset = 1'b0;
        if (core_done)      w_next = S_ADVANCE;
        else if (w_timeout) w_next = S_FINISH;
      end
      S_ADVANCE: begin
        busy = 1'b1;
        if (w_last_thread && w_last_block) w_next = S_FINISH;
        else                               w_next = S_CORE_RST;
      end
      S_FINISH: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_num_blocks   <= '0;
      r_block_dim    <= '0;
      r_block_idx    <= '0;
      r_thread_idx   <= '0;
      r_threads_done <= '0;
      r_error        <= 1'b0;
      r_rst_cnt      <= '0;
      r_wdog         <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_num_blocks   <= num_blocks;
            r_block_dim    <= block_dim_in;
            r_block_idx    <= '0;
            r_thread_idx   <= '0;
            r_threads_done <= '0;
            r_error        <= 1'b0;
            r_rst_cnt      <= '0;
          end
        end
        S_CORE_RST: begin
          r_rst_cnt <= r_rst_cnt + RCW'(1);
          r_wdog    <= '0;
        end
        S_RUN: begin
          r_wdog <= r_wdog + WCW'(1);
          if (core_done)      r_threads_done <= r_threads_done + WIDTH'(1);
          else if (w_timeout) r_error        <= 1'b1;
        end
        S_ADVANCE: begin
          r_rst_cnt <= '0;
          // Indices stay on the final pair once the launch is complete.
          if (!(w_last_thread && w_last_block)) begin
            if (w_last_thread) begin
              r_thread_idx <= '0;
              r_block_idx  <= r_block_idx + WIDTH'(1);
            end else begin
              r_thread_idx <= r_thread_idx + WIDTH'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign core_block_idx  = r_block_idx;
  assign core_thread_idx = r_thread_idx;
  assign core_block_dim  = r_block_dim;
  assign threads_done    = r_threads_done;
  assign error           = r_error;

endmodule

// File: tb/tb_thread_dispatcher.sv
// Bench for thread_dispatcher: per-launch expected cycle traces built from the launch rules, compared every cycle.
module tb_thread_dispatcher;

  localparam int W   = 16;
  localparam int RC  = 2;
  localparam int TO  = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] num_blocks;
  logic [W-1:0] block_dim_in;
  logic         core_done;
  logic         core_reset;
  logic [W-1:0] core_block_idx;
  logic [W-1:0] core_thread_idx;
  logic [W-1:0] core_block_dim;
  logic         busy;
  logic         done;
  logic         error;
  logic [W-1:0] threads_done;

  thread_dispatcher #(.WIDTH(W), .RST_CYCLES(RC), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .num_blocks(num_blocks),
    .block_dim_in(block_dim_in), .core_done(core_done), .core_reset(core_reset),
    .core_block_idx(core_block_idx), .core_thread_idx(core_thread_idx),
    .core_block_dim(core_block_dim), .busy(busy), .done(done), .error(error),
    .threads_done(threads_done)
  );

  always #5 clk = ~clk;

  // One entry per clock cycle: inputs to drive and outputs expected during that cycle.
  typedef struct {
    bit          st;
    bit          rs;
    bit          cd;
    int          nbv;
    int          dmv;
    logic [67:0] exp;
  } ent_t;

  ent_t q[$];
  int   plan[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   g_idx   = 0;
  int   seg_start;
  int   done_cnt, done_at, done_td, done_err;

  // Model of the launch-visible state between launches.
  int m_bi = 0, m_ti = 0, m_bd = 0, m_td = 0;
  bit m_err = 1'b0;

  function automatic logic [67:0] mk(bit cr, bit by, bit dn, bit er, int bi, int ti, int bd, int td);
    return {cr, by, dn, er, 16'(bi), 16'(ti), 16'(bd), 16'(td)};
  endfunction

  task automatic push(bit st, int nbv, int dmv, bit cd, bit rs, logic [67:0] e);
    ent_t x;
    x.st = st; x.nbv = nbv; x.dmv = dmv; x.cd = cd; x.rs = rs; x.exp = e;
    q.push_back(x);
  endtask

  function automatic logic [67:0] idle_exp();
    return mk(1, 0, 0, m_err, m_bi, m_ti, m_bd, m_td);
  endfunction

  task automatic idle(int n);
    for (int i = 0; i < n; i++)
      push(0, $urandom_range(0, 5), $urandom_range(0, 5), 1'($urandom_range(0, 1)), 0, idle_exp());
  endtask

  // Stray start while busy: mode 0 never, 1 every cycle, 2 random.
  function automatic bit noise(int mode);
    if (mode == 1) return 1'b1;
    if (mode == 2) return ($urandom_range(0, 2) == 0);
    return 1'b0;
  endfunction

  task automatic launch(int nb, int dim, bit cd_in_rst, int nmode, bit do_rst, int rb, int rt, int rk);
    int r, lim;
    seg_start = g_idx + q.size();
    push(1, nb, dim, 1'($urandom_range(0, 1)), 0, idle_exp());
    m_bd = dim; m_bi = 0; m_ti = 0; m_td = 0; m_err = 1'b0;
    if (nb == 0 || dim == 0) begin
      push(noise(nmode), 9, 3, 1'($urandom_range(0, 1)), 0, mk(1, 0, 1, 0, 0, 0, dim, 0));
      return;
    end
    for (int b = 0; b < nb; b++) begin
      for (int t = 0; t < dim; t++) begin
        m_bi = b; m_ti = t;
        for (int c = 0; c < RC; c++)
          push(noise(nmode), 9, 3, cd_in_rst ? 1'b1 : 1'($urandom_range(0, 1)), 0,
               mk(1, 1, 0, 0, b, t, dim, m_td));
        if (plan.size() > 0) r = plan.pop_front();
        else r = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TO);
        lim = (r == 0) ? TO : r;
        for (int k = 1; k <= lim; k++) begin
          if (do_rst && b == rb && t == rt && k == rk) begin
            push(0, 9, 3, 0, 1, mk(0, 1, 0, 0, b, t, dim, m_td));
            m_bi = 0; m_ti = 0; m_bd = 0; m_td = 0; m_err = 1'b0;
            return;
          end
          push(noise(nmode), 9, 3, (k == r), 0, mk(0, 1, 0, 0, b, t, dim, m_td));
        end
        if (r == 0) begin
          m_err = 1'b1;
          push(noise(nmode), 9, 3, 1'($urandom_range(0, 1)), 0, mk(1, 0, 1, 1, b, t, dim, m_td));
          return;
        end
        m_td++;
        push(noise(nmode), 9, 3, 1'($urandom_range(0, 1)), 0, mk(1, 1, 0, 0, b, t, dim, m_td));
        if (b == nb - 1 && t == dim - 1) begin
          push(noise(nmode), 9, 3, 1'($urandom_range(0, 1)), 0, mk(1, 0, 1, 0, b, t, dim, m_td));
          return;
        end
      end
    end
  endtask

  task automatic check(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic run_queue();
    ent_t        e;
    logic [67:0] act;
    done_cnt = 0; done_at = -1; done_td = -1; done_err = -1;
    while (q.size() > 0) begin
      e = q.pop_front();
      @(posedge clk); #1;
      reset        = e.rs;
      start        = e.st;
      num_blocks   = 16'(e.nbv);
      block_dim_in = 16'(e.dmv);
      core_done    = e.cd;
      @(negedge clk);
      act = {core_reset, busy, done, error, core_block_idx, core_thread_idx, core_block_dim, threads_done};
      n_tests++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL trace[%0d] {rst,busy,done,err,blk,thr,dim,cnt}: got %h, want %h", g_idx, act, e.exp);
      end
      if (done === 1'b1) begin
        done_cnt++; done_at = g_idx; done_td = int'(threads_done); done_err = int'(error);
      end
      g_idx++;
    end
  endtask

  function automatic int first_done_in_q();
    for (int i = 0; i < q.size(); i++)
      if (q[i].exp[65]) return i;
    return -1;
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; num_blocks = '0; block_dim_in = '0; core_done = 1'b0;
    repeat (2) @(posedge clk);

    // Power-up state.
    idle(3);
    run_queue();

    // 2x3 grid, every thread finishes on RUN cycle 5: 6 * (2+5+1) cycles then FINISH.
    plan = '{5, 5, 5, 5, 5, 5};
    launch(2, 3, 0, 0, 0, 0, 0, 0);
    check("model_2x3_done_offset", first_done_in_q() - (seg_start - g_idx), 49);
    idle(2);
    run_queue();
    check("2x3_done_pulses", done_cnt, 1);
    check("2x3_done_latency", done_at - seg_start, 49);
    check("2x3_threads_done", done_td, 6);
    check("2x3_error", done_err, 0);

    // Empty grid: done on the cycle right after start.
    launch(0, 4, 0, 0, 0, 0, 0, 0);
    idle(2);
    run_queue();
    check("empty_done_latency", done_at - seg_start, 1);
    check("empty_threads_done", done_td, 0);

    // Watchdog: RUN lasts TO cycles without core_done.
    plan = '{0};
    launch(1, 1, 0, 0, 0, 0, 0, 0);
    idle(2);
    run_queue();
    check("timeout_done_latency", done_at - seg_start, 1 + RC + TO);
    check("timeout_error", done_err, 1);
    check("timeout_threads_done", done_td, 0);

    // Next start clears error; second thread's done coincides with the watchdog limit.
    plan = '{1, TO};
    launch(1, 2, 0, 0, 0, 0, 0, 0);
    idle(2);
    run_queue();
    check("clear_error", done_err, 0);
    check("tie_threads_done", done_td, 2);
    check("tie_done_latency", done_at - seg_start, 1 + (RC + 1 + 1) + (RC + TO + 1));

    // core_done held high through CORE_RST must not advance.
    plan = '{3};
    launch(1, 1, 1, 0, 0, 0, 0, 0);
    idle(1);
    run_queue();
    check("cd_in_rst_latency", done_at - seg_start, 1 + RC + 3 + 1);

    // start held high (num_blocks=9) for the whole launch is ignored.
    plan = '{3, 3, 3, 3};
    launch(2, 2, 0, 1, 0, 0, 0, 0);
    idle(2);
    run_queue();
    check("busy_start_threads_done", done_td, 4);
    check("busy_start_latency", done_at - seg_start, 25);

    // Reset during RUN of thread (1,1) abandons the launch.
    plan = '{4, 4, 4, 4};
    launch(2, 2, 0, 0, 1, 1, 1, 2);
    idle(3);
    run_queue();
    check("reset_no_done", done_cnt, 0);

    plan = '{2};
    launch(1, 1, 0, 0, 0, 0, 0, 0);
    idle(1);
    run_queue();
    check("post_reset_latency", done_at - seg_start, 1 + RC + 2 + 1);
    check("post_reset_threads_done", done_td, 1);

    // Randomized launches.
    for (int n = 0; n < 25; n++) begin
      launch($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 2, 0, 0, 0, 0);
      idle($urandom_range(1, 3));
      run_queue();
      check("random_done_pulses", done_cnt, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
